// File: rtl/dbg_uart_loader.sv
`default_nettype none
// ============================================================================
// dbg_uart_loader : UART command frames -> SoC debug memory port host
// Revision: 1.0
// ============================================================================
module dbg_uart_loader #(
  parameter int unsigned MEM_CYCLES       = 4,
  parameter int unsigned RX_TIMEOUT       = 100000,
  parameter bit          HOLD_AFTER_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam logic [7:0] c_cmd_w   = 8'h57;
  localparam logic [7:0] c_cmd_r   = 8'h52;
  localparam logic [7:0] c_cmd_h   = 8'h48;
  localparam logic [7:0] c_cmd_g   = 8'h47;
  localparam logic [7:0] c_rsp_k   = 8'h4B;
  localparam logic [7:0] c_rsp_err = 8'h45;
  localparam logic [7:0] c_rsp_unk = 8'h3F;

  localparam int unsigned     TO_W       = $clog2(RX_TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_to_last  = TO_W'(RX_TIMEOUT - 1);
  localparam logic [7:0]      c_mem_last = 8'(MEM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            is_w_q, is_w_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     do_q, do_d;
  logic [31:0]     resp_q, resp_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_q, last_d;
  logic [7:0]      mem_cnt_q, mem_cnt_d;
  logic            mem_op_q, mem_op_d;
  logic [3:0]      wren_q, wren_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            cpu_n_reset_q, cpu_n_reset_d;
  logic            w_frame_done;
  logic [1:0]      w_next_idx;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_w_d        = is_w_q;
    adr_d         = adr_q;
    do_d          = do_q;
    resp_d        = resp_q;
    idx_d         = idx_q;
    last_d        = last_q;
    mem_cnt_d     = mem_cnt_q;
    mem_op_d      = mem_op_q;
    wren_d        = wren_q;
    to_d          = to_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    cpu_n_reset_d = cpu_n_reset_q;
    w_frame_done  = 1'b0;
    w_next_idx    = idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cnt_d   = 2'd0;
          to_d    = '0;
          idx_d   = 2'd0;
          last_d  = 2'd0;
          resp_d  = {24'h0, c_rsp_k};
          state_d = S_RESP;
          case (rx_data)
            c_cmd_w: begin is_w_d = 1'b1; state_d = S_ADDR; end
            c_cmd_r: begin is_w_d = 1'b0; state_d = S_ADDR; end
            c_cmd_h: cpu_n_reset_d = 1'b0;
            c_cmd_g: cpu_n_reset_d = 1'b1;
            default: resp_d = {24'h0, c_rsp_unk};
          endcase
        end
      end

      // Each byte lands directly in its lane; a byte beats a same-cycle timeout.
      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          to_d  = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            adr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          end else begin
            do_d[{cnt_q, 3'b000} +: 8] = rx_data;
          end
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && is_w_q) begin
              state_d = S_DATA;
            end else begin
              w_frame_done = 1'b1;
            end
          end
        end else if (to_q == c_to_last) begin
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_ACCESS: begin
        if (mem_cnt_q == c_mem_last) begin
          mem_op_d = 1'b0;
          wren_d   = 4'h0;
          state_d  = S_RESP;
          if (is_w_q) begin
            resp_d = {24'h0, c_rsp_k};
          end else begin
            resp_d = dbg_di;
            last_d = 2'd3;
          end
        end else begin
          mem_cnt_d = mem_cnt_q + 8'd1;
        end
      end

      // tx_valid low inside RESP only on the entry cycle.
      S_RESP: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = resp_q[{idx_q, 3'b000} +: 8];
        end else if (tx_ready) begin
          if (idx_q == last_q) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            idx_d     = w_next_idx;
            tx_data_d = resp_q[{w_next_idx, 3'b000} +: 8];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A running CPU owns the bus, so a complete W/R frame only earns an error.
    if (w_frame_done) begin
      mem_cnt_d = 8'd0;
      idx_d     = 2'd0;
      last_d    = 2'd0;
      if (cpu_n_reset_q) begin
        resp_d  = {24'h0, c_rsp_err};
        state_d = S_RESP;
      end else begin
        state_d  = S_ACCESS;
        mem_op_d = 1'b1;
        wren_d   = is_w_q ? 4'hF : 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      is_w_q        <= 1'b0;
      adr_q         <= 32'h0;
      do_q          <= 32'h0;
      resp_q        <= 32'h0;
      idx_q         <= 2'd0;
      last_q        <= 2'd0;
      mem_cnt_q     <= 8'd0;
      mem_op_q      <= 1'b0;
      wren_q        <= 4'h0;
      to_q          <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h0;
      cpu_n_reset_q <= ~HOLD_AFTER_RESET;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_w_q        <= is_w_d;
      adr_q         <= adr_d;
      do_q          <= do_d;
      resp_q        <= resp_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      mem_cnt_q     <= mem_cnt_d;
      mem_op_q      <= mem_op_d;
      wren_q        <= wren_d;
      to_q          <= to_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      cpu_n_reset_q <= cpu_n_reset_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_wren    = wren_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign cpu_n_reset = cpu_n_reset_q;

endmodule
`default_nettype wire
